// File: rtl/ca_code_sched.sv
// ca_code_sched: chip-rate controller for the GPS C/A code generator.
// Accepts a PRN/phase/rate configuration over a valid/ready handshake, pulses
// the code generator load, slews the code to the requested chip offset, then
// issues chip-advance strobes from the carry of a code NCO.
// It also tracks chip index, 1 ms code epochs and navigation-bit boundaries.
//
// Ports:
//   CLOCK_50, rst               clock, async active-high reset
//   cfg_valid/cfg_ready         configuration handshake (ready only in IDLE)
//   cfg_t0, cfg_t1              G2 tap selects
//   cfg_fcw                     code NCO frequency control word
//   cfg_phase                   initial chip offset 0..1022
//   stop                        abort to IDLE
//   ca_load, ca_t0, ca_t1       load pulse and tap selects to cacode
//   ca_rd                       chip-advance strobe to cacode
//   chip_idx, epoch             chip index and code-wrap pulse
//   ms_cnt, bit_edge            epoch counter and nav-bit-wrap pulse
//   busy                        high in LOAD, SLEW and RUN
//
// Optional feature macro CA_SCHED_DOPPLER_EN adds fcw_delta/fcw_upd, which
// nudge the working FCW while in RUN.
module ca_code_sched #(
  parameter int unsigned NCO_W          = 32,
  parameter int unsigned CODE_LEN       = 1023,
  parameter int unsigned EPOCHS_PER_BIT = 20
) (
  input  logic                CLOCK_50,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [3:0]          cfg_t0,
  input  logic [3:0]          cfg_t1,
  input  logic [NCO_W-1:0]    cfg_fcw,
  input  logic [9:0]          cfg_phase,
  input  logic                stop,
`ifdef CA_SCHED_DOPPLER_EN
  input  logic signed [15:0]  fcw_delta,
  input  logic                fcw_upd,
`endif
  output logic                ca_load,
  output logic [3:0]          ca_t0,
  output logic [3:0]          ca_t1,
  output logic                ca_rd,
  output logic [9:0]          chip_idx,
  output logic                epoch,
  output logic [4:0]          ms_cnt,
  output logic                bit_edge,
  output logic                busy
);

  localparam int unsigned CHIP_W = 10;
  localparam int unsigned MS_W   = 5;
  localparam int unsigned TAP_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SLEW,
    S_RUN
  } state_t;

  state_t state, state_d;

  logic [NCO_W-1:0]  acc, acc_d;
  logic [NCO_W-1:0]  fcw, fcw_d;
  logic [CHIP_W-1:0] phase, phase_d;
  logic [CHIP_W-1:0] slew_cnt, slew_cnt_d;
  logic [NCO_W:0]    sum;
  logic              carry;

  logic              cfg_ready_d, busy_d, ca_load_d, ca_rd_d, epoch_d, bit_edge_d;
  logic [TAP_W-1:0]  ca_t0_d, ca_t1_d;
  logic [CHIP_W-1:0] chip_idx_d;
  logic [MS_W-1:0]   ms_cnt_d;

  // NCO adder; bit NCO_W is the carry that becomes a chip strobe
  always_comb begin
    sum   = {1'b0, acc} + {1'b0, fcw};
    carry = sum[NCO_W];
  end

  // State register
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state;
    acc_d      = acc;
    fcw_d      = fcw;
    phase_d    = phase;
    slew_cnt_d = slew_cnt;
    ca_t0_d    = ca_t0;
    ca_t1_d    = ca_t1;
    chip_idx_d = chip_idx;
    ms_cnt_d   = ms_cnt;
    ca_load_d  = 1'b0;
    ca_rd_d    = 1'b0;
    epoch_d    = 1'b0;
    bit_edge_d = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (cfg_valid && cfg_ready) begin
          state_d    = S_LOAD;
          ca_t0_d    = cfg_t0;
          ca_t1_d    = cfg_t1;
          fcw_d      = cfg_fcw;
          phase_d    = cfg_phase;
          ca_load_d  = 1'b1;
          chip_idx_d = '0;
          ms_cnt_d   = '0;
          acc_d      = '0;
        end
      end

      S_LOAD: begin
        // The first slew strobe is issued on the edge that leaves LOAD, so the
        // counter holds the number of strobes still to come after it.
        if (phase == '0) begin
          state_d = S_RUN;
        end else begin
          state_d    = S_SLEW;
          ca_rd_d    = 1'b1;
          chip_idx_d = chip_idx + CHIP_W'(1);
          slew_cnt_d = phase - CHIP_W'(1);
        end
      end

      S_SLEW: begin
        if (slew_cnt == '0) begin
          state_d = S_RUN;
        end else begin
          ca_rd_d    = 1'b1;
          chip_idx_d = chip_idx + CHIP_W'(1);
          slew_cnt_d = slew_cnt - CHIP_W'(1);
        end
      end

      S_RUN: begin
        acc_d = sum[NCO_W-1:0];
        if (carry) begin
          ca_rd_d = 1'b1;
          if (chip_idx == CHIP_W'(CODE_LEN - 1)) begin
            chip_idx_d = '0;
            epoch_d    = 1'b1;
            if (ms_cnt == MS_W'(EPOCHS_PER_BIT - 1)) begin
              ms_cnt_d   = '0;
              bit_edge_d = 1'b1;
            end else begin
              ms_cnt_d = ms_cnt + MS_W'(1);
            end
          end else begin
            chip_idx_d = chip_idx + CHIP_W'(1);
          end
        end
`ifdef CA_SCHED_DOPPLER_EN
        // Updated FCW is used from the following accumulate onward
        if (fcw_upd) fcw_d = fcw + NCO_W'(fcw_delta);
`endif
      end

      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a coincident NCO carry
    if (stop && (state != S_IDLE)) begin
      state_d    = S_IDLE;
      fcw_d      = fcw;
      ca_rd_d    = 1'b0;
      epoch_d    = 1'b0;
      bit_edge_d = 1'b0;
      ca_load_d  = 1'b0;
      chip_idx_d = '0;
      ms_cnt_d   = '0;
      acc_d      = '0;
    end

    cfg_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // Datapath and registered outputs
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      fcw       <= '0;
      phase     <= '0;
      slew_cnt  <= '0;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
      ca_load   <= 1'b0;
      ca_t0     <= '0;
      ca_t1     <= '0;
      ca_rd     <= 1'b0;
      chip_idx  <= '0;
      epoch     <= 1'b0;
      ms_cnt    <= '0;
      bit_edge  <= 1'b0;
    end else begin
      acc       <= acc_d;
      fcw       <= fcw_d;
      phase     <= phase_d;
      slew_cnt  <= slew_cnt_d;
      cfg_ready <= cfg_ready_d;
      busy      <= busy_d;
      ca_load   <= ca_load_d;
      ca_t0     <= ca_t0_d;
      ca_t1     <= ca_t1_d;
      ca_rd     <= ca_rd_d;
      chip_idx  <= chip_idx_d;
      epoch     <= epoch_d;
      ms_cnt    <= ms_cnt_d;
      bit_edge  <= bit_edge_d;
    end
  end

endmodule
